// File: rtl/thermal_covert_tx_if.sv
// thermal_covert_tx_if: valid/ready message handshake between message source and transmitter
interface thermal_covert_tx_if #(parameter int MSG_W = 8);
    logic             msg_valid;
    logic [MSG_W-1:0] msg_data;
    logic             msg_ready;
    modport master (output msg_valid, output msg_data, input msg_ready);
    modport slave (input msg_valid, input msg_data, output msg_ready);
endinterface

// File: rtl/thermal_covert_tx.sv
// thermal_covert_tx: frames a message into timed heater periods and measures a sense oscillator per bit window
module thermal_covert_tx #(
    parameter int HEATER_W = 75,
    parameter int BIT_CYCLES = 2**26,
    parameter int MSG_W = 8,
    parameter int CNT_W = 20,
    parameter int DISP_NIBBLES = 3,
    parameter int SLOT_CYCLES = 2**22
) (
    input  logic                clk,
    input  logic                rst_n,
    thermal_covert_tx_if.slave  msg,
    output logic                busy,
    output logic                heater_on,
    output logic                heater_tap,
    input  logic                sense_in,
    output logic [CNT_W-1:0]    sample_count,
    output logic                sample_valid,
    output logic [3:0]          led
);
    localparam int TW = $clog2(BIT_CYCLES);
    localparam int STW = SLOT_CYCLES > 1 ? $clog2(SLOT_CYCLES) : 1;
    localparam int BW = MSG_W > 1 ? $clog2(MSG_W) : 1;
    localparam int SW = $clog2(DISP_NIBBLES + 1);
    localparam int PW = 4 * DISP_NIBBLES + 4;
    typedef enum logic [1:0] {IDLE, PRE, DATA, GUARD} state_t;
    state_t              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [MSG_W-1:0]    shift_q, shift_d;
    logic                ready_q, ready_d, busy_q, busy_d, heat_q, heat_d, valid_q, valid_d;
    logic [HEATER_W-1:0] bank_q, bank_d;
    logic [2:0]          sync_q, sync_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, sample_q, sample_d, cnt_inc;
    logic [STW-1:0]      stimer_q, stimer_d;
    logic [SW-1:0]       slot_q, slot_d;
    logic [3:0]          led_q, led_d;
    logic [PW-1:0]       disp;
    logic                accept, tc, stc, edge_det;
    always_comb begin
        accept = msg.msg_valid & ready_q;
        tc = timer_q == TW'(BIT_CYCLES - 1);
        state_d = state_q;
        bit_d = bit_q;
        shift_d = shift_q;
        timer_d = (accept || tc) ? '0 : timer_q + 1'b1;
        unique case (state_q)
            IDLE: if (accept) begin
                state_d = PRE;
                shift_d = msg.msg_data;
            end
            PRE: if (tc) begin
                state_d = DATA;
                bit_d = BW'(MSG_W - 1);
            end
            DATA: if (tc) begin
                shift_d = shift_q << 1;
                bit_d = bit_q - 1'b1;
                state_d = (bit_q == '0) ? GUARD : DATA;
            end
            GUARD: if (tc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = state_d == IDLE;
        busy_d = state_d != IDLE;
        heat_d = state_d == PRE || (state_d == DATA && shift_d[MSG_W-1]);
        bank_d = heat_q ? ~bank_q : bank_q;
        // sync_q[1] is the synchronised sample, sync_q[2] its previous value
        sync_d = {sync_q[1:0], sense_in};
        edge_det = sync_q[1] & ~sync_q[2];
        cnt_inc = cnt_q + CNT_W'(edge_det & ~&cnt_q);
        cnt_d = (accept || tc) ? '0 : cnt_inc;
        sample_d = tc ? cnt_inc : sample_q;
        valid_d = tc;
        stc = stimer_q == STW'(SLOT_CYCLES - 1);
        stimer_d = stc ? '0 : stimer_q + 1'b1;
        slot_d = stc ? ((slot_q == SW'(DISP_NIBBLES)) ? '0 : slot_q + 1'b1) : slot_q;
        disp = PW'({sample_q, 4'b0000});
        led_d = disp[{slot_q, 2'b00} +: 4];
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            bit_q <= '0;
            shift_q <= '0;
            ready_q <= 1'b0;
            busy_q <= 1'b0;
            heat_q <= 1'b0;
            bank_q <= '0;
            sync_q <= '0;
            cnt_q <= '0;
            sample_q <= '0;
            valid_q <= 1'b0;
            stimer_q <= '0;
            slot_q <= '0;
            led_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q <= bit_d;
            shift_q <= shift_d;
            ready_q <= ready_d;
            busy_q <= busy_d;
            heat_q <= heat_d;
            bank_q <= bank_d;
            sync_q <= sync_d;
            cnt_q <= cnt_d;
            sample_q <= sample_d;
            valid_q <= valid_d;
            stimer_q <= stimer_d;
            slot_q <= slot_d;
            led_q <= led_d;
        end
    end
    assign msg.msg_ready = ready_q;
    assign busy = busy_q;
    assign heater_on = heat_q;
    assign heater_tap = ^bank_q;
    assign sample_count = sample_q;
    assign sample_valid = valid_q;
    assign led = led_q;
endmodule

// File: tb/tb_thermal_covert_tx.sv
// tb_thermal_covert_tx: randomized and directed checks of thermal_covert_tx against a timestamp-based model
module tb_thermal_covert_tx;
    localparam int BC = 8, MW = 8, CW = 12, DN = 3, SC = 4, HW = 5, F = (MW + 2) * BC;
    logic clk = 0, rst_n = 0, sense_in = 0, rst2_n = 0, sense2 = 0;
    logic busy, heater_on, heater_tap, sample_valid;
    logic [CW-1:0] sample_count;
    logic [3:0] led;
    logic busy2, heat2, tap2, valid2;
    logic [2:0] count2;
    logic [3:0] led2;
    thermal_covert_tx_if #(.MSG_W(MW)) m_if();
    thermal_covert_tx_if #(.MSG_W(MW)) m2_if();
    thermal_covert_tx #(.HEATER_W(HW), .BIT_CYCLES(BC), .MSG_W(MW), .CNT_W(CW), .DISP_NIBBLES(DN),
        .SLOT_CYCLES(SC)) dut (.clk(clk), .rst_n(rst_n), .msg(m_if), .busy(busy), .heater_on(heater_on),
        .heater_tap(heater_tap), .sense_in(sense_in), .sample_count(sample_count),
        .sample_valid(sample_valid), .led(led));
    thermal_covert_tx #(.HEATER_W(HW), .BIT_CYCLES(32), .MSG_W(MW), .CNT_W(3), .DISP_NIBBLES(1),
        .SLOT_CYCLES(SC)) dut2 (.clk(clk), .rst_n(rst2_n), .msg(m2_if), .busy(busy2), .heater_on(heat2),
        .heater_tap(tap2), .sense_in(sense2), .sample_count(count2), .sample_valid(valid2), .led(led2));
    always #5 clk = ~clk;
    int errors = 0, checks = 0;
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask
    function automatic logic [3:0] nib(input int s, input int k);
        return (k == 0) ? 4'd0 : 4'((s >> (4 * (k - 1))) & 15);
    endfunction
    int cyc = 0, tstart = 0, rlast = 0, fstart = -1000000, acc = 0, e_sample = 0, prev_sample, ed, k, p;
    logic [MW-1:0] fmsg = '0;
    logic e_ready = 0, e_busy = 0, e_heat = 0, e_tap = 0, e_valid = 0, tc, sv1 = 0, sv2 = 0, sv3 = 0;
    logic [3:0] e_led = 0;
    // Model: outputs after each edge derived from reset/accept timestamps and the sampled sense history
    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            tstart = cyc; rlast = cyc; fstart = -1000000; acc = 0; e_sample = 0;
            e_ready = 0; e_busy = 0; e_heat = 0; e_tap = 0; e_valid = 0; e_led = 0;
            sv1 = 0; sv2 = 0; sv3 = 0;
        end else begin
            ed = int'(sv2 & ~sv3);
            sv3 = sv2; sv2 = sv1; sv1 = sense_in;
            prev_sample = e_sample;
            e_led = nib(prev_sample, ((cyc - 1 - rlast) / SC) % (DN + 1));
            e_tap = e_tap ^ (e_heat & (HW % 2 == 1));
            tc = ((cyc - 1 - tstart) % BC) == BC - 1;
            acc = (acc + ed > 2**CW - 1) ? 2**CW - 1 : acc + ed;
            e_valid = tc;
            if (tc) begin
                e_sample = acc;
                acc = 0;
            end
            if (m_if.msg_valid && e_ready) begin
                tstart = cyc; fstart = cyc; fmsg = m_if.msg_data; acc = 0;
            end
            k = cyc - fstart;
            e_busy = k >= 0 && k < F;
            p = k / BC;
            e_heat = e_busy && (p == 0 || (p <= MW && fmsg[MW-p]));
            e_ready = !e_busy;
        end
    end
    int n2 = 0;
    initial forever begin
        @(negedge clk);
        check("msg_ready", m_if.msg_ready, e_ready);
        check("busy", busy, e_busy);
        check("heater_on", heater_on, e_heat);
        check("heater_tap", heater_tap, e_tap);
        check("sample_valid", sample_valid, e_valid);
        check("sample_count", sample_count, e_sample);
        check("led", led, e_led);
        if (valid2) begin
            n2++;
            if (n2 > 1) check("sat_count", count2, 7);
        end
    end
    initial begin
        repeat (3) @(posedge clk);
        #1 rst2_n = 1;
        forever begin
            repeat (2) @(posedge clk);
            #1 sense2 = ~sense2;
        end
    end
    int nb, nv, n_led;
    logic done;
    logic [9:0] heat_log;
    logic [9:0] heat_exp = 10'b1101001010;
    initial begin
        m_if.msg_valid = 0; m_if.msg_data = 0; m2_if.msg_valid = 0; m2_if.msg_data = 0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("ready_before_edge", m_if.msg_ready, 0);
        @(negedge clk);
        check("ready_after_release", m_if.msg_ready, 1);
        @(posedge clk);
        #1 m_if.msg_valid = 1; m_if.msg_data = 8'hA5;
        nb = 0; done = 0; heat_log = '0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (busy) begin
                if (nb % BC == 3) heat_log[9 - nb / BC] = heater_on;
                nb++;
            end
            if (m_if.msg_ready && nb > 0) done = 1;
        end
        m_if.msg_valid = 0;
        check("frame_done", done, 1);
        check("frame_busy_cycles", nb, F);
        check("heater_pattern_A5", heat_log, heat_exp);
        nv = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1 sense_in = i[1];
            @(negedge clk);
            if (i > 24 && sample_valid) begin
                nv++;
                check("steady_count", sample_count, 2);
            end
        end
        check("steady_pulses", nv >= 6, 1);
        n_led = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (led != 0) begin
                n_led++;
                check("led_value", led, 2);
            end
        end
        check("led_nonzero_slots", n_led, 4);
        @(posedge clk);
        #1 sense_in = 0; m_if.msg_valid = 1; m_if.msg_data = 8'hFF;
        @(posedge clk);
        #1 m_if.msg_valid = 0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("heater_mid_data", heater_on, 1);
        @(posedge clk);
        #1 rst_n = 0;
        @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("abort_heater", heater_on, 0);
        check("abort_busy", busy, 0);
        check("abort_tap", heater_tap, 0);
        @(posedge clk);
        #1 m_if.msg_valid = 1; m_if.msg_data = 8'h3C;
        @(posedge clk);
        #1 m_if.msg_valid = 0;
        @(negedge clk);
        check("accept_after_abort", busy, 1);
        for (int i = 0; i < 2500; i++) begin
            @(posedge clk);
            #1;
            m_if.msg_valid = $urandom_range(0, 3) == 0;
            m_if.msg_data = 8'($urandom);
            sense_in = 1'($urandom_range(0, 1));
            rst_n = (i > 2490) || ($urandom_range(0, 499) != 0);
        end
        repeat (4) @(posedge clk);
        check("sat_pulses_seen", n2 >= 3, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
